// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: reads one word per PC change over a req/ready memory port and
// holds it for the decoder. Optional watchdog retry is enabled with `define IF_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_address,
    input  logic                  flush,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  fetch_busy,
    output logic [15:0]           fetch_count,
    output logic                  fetch_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_tag_valid;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_mem_rd;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_instr_addr;
    logic                  r_instr_valid;
    logic [15:0]           r_fetch_count;
    logic                  w_need_fetch;

`ifdef IF_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    logic [7:0]            r_wdog;
    logic                  r_fetch_error;
`endif

    assign w_need_fetch = !r_tag_valid || (pc_address != r_tag);

    // Busy is combinational so the control unit freezes the PC in the same cycle a change is seen.
    assign fetch_busy = !reset && (((r_state == S_IDLE) && w_need_fetch) ||
                                   (r_state == S_REQ) || (r_state == S_WAIT) ||
                                   (r_state == S_DRAIN));

    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_req_addr;
    assign instr       = r_instr;
    assign instr_addr  = r_instr_addr;
    assign instr_valid = r_instr_valid;
    assign fetch_count = r_fetch_count;
`ifdef IF_TIMEOUT_EN
    assign fetch_error = r_fetch_error;
`else
    assign fetch_error = 1'b0;
`endif

    // NOTE: all state updates use <= so every branch below reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_tag_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_instr       <= '0;
            r_instr_addr  <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_count <= '0;
`ifdef IF_TIMEOUT_EN
            r_wdog        <= '0;
            r_fetch_error <= 1'b0;
`endif
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush || w_need_fetch) begin
                        r_req_addr <= pc_address;
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_REQ;
                        if (flush) r_tag_valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    // The request has left this cycle, so a flush here must still drain its response.
                    r_state <= flush ? S_DRAIN : S_WAIT;
`ifdef IF_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        if (flush) begin
                            r_tag_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_instr       <= mem_rdata;
                            r_instr_addr  <= r_req_addr;
                            r_tag         <= r_req_addr;
                            r_tag_valid   <= 1'b1;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
`ifdef IF_TIMEOUT_EN
                        r_wdog  <= '0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_fetch_error <= 1'b1;
                        r_mem_rd      <= 1'b1;
                        r_state       <= S_REQ;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
`endif
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        r_tag_valid   <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (instr_ready) begin
                        r_fetch_count <= r_fetch_count + 16'd1;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (pc_address != r_tag) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_ready) begin
                        r_tag_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifdef IF_TIMEOUT_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_tag_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] pc_address = '0;
    logic        flush = 1'b0;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic [19:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fetch_busy;
    logic [15:0] fetch_count;
    logic        fetch_error;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .pc_address  (pc_address),
        .flush       (flush),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_busy  (fetch_busy),
        .fetch_count (fetch_count),
        .fetch_error (fetch_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    // PC was changed at the current falling edge; the request appears one cycle later.
    task automatic expect_req(input string tag, input logic [19:0] addr);
        step();
        check({tag, " mem_rd"}, 32'(mem_rd), 32'd1);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
        check({tag, " busy"}, 32'(fetch_busy), 32'd1);
    endtask

    // From the REQ cycle: answer in the first WAIT cycle, then see the word held.
    task automatic respond(input string tag, input logic [19:0] addr, input logic [31:0] data);
        step();
        check({tag, " mem_rd pulse"}, 32'(mem_rd), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = data;
        step();
        mem_ready = 1'b0;
        check({tag, " valid"}, 32'(instr_valid), 32'd1);
        check({tag, " instr"}, instr, data);
        check({tag, " instr_addr"}, 32'(instr_addr), 32'(addr));
        check({tag, " busy hold"}, 32'(fetch_busy), 32'd0);
    endtask

    task automatic accept(input string tag, input logic [15:0] exp_count);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check({tag, " valid drop"}, 32'(instr_valid), 32'd0);
        check({tag, " count"}, 32'(fetch_count), 32'(exp_count));
    endtask

    initial begin
        int pulses;

        // Reset state
        step(2);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst instr", instr, 32'd0);
        check("rst count", 32'(fetch_count), 32'd0);
        check("rst error", 32'(fetch_error), 32'd0);
        check("rst busy", 32'(fetch_busy), 32'd0);

        // 1: first fetch at PC 0, accepted
        reset = 1'b0;
        pc_address = 20'h00000;
        expect_req("t1", 20'h00000);
        respond("t1", 20'h00000, 32'hDEADBEEF);
        accept("t1", 16'd1);

        // 2: decoder stalls for 5 cycles, then a constant PC must not refetch
        pc_address = 20'h00001;
        expect_req("t2", 20'h00001);
        respond("t2", 20'h00001, 32'hCAFE0001);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(mem_rd);
            check("t2 stall instr", instr, 32'hCAFE0001);
            check("t2 stall valid", 32'(instr_valid), 32'd1);
            check("t2 stall busy", 32'(fetch_busy), 32'd0);
        end
        check("t2 stall mem_rd", 32'(pulses), 32'd0);
        accept("t2", 16'd2);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(mem_rd);
        end
        check("t2 no refetch", 32'(pulses), 32'd0);
        check("t2 idle busy", 32'(fetch_busy), 32'd0);

        // 3: flush while waiting; late response is discarded, then the PC is refetched
        pc_address = 20'h00002;
        expect_req("t3", 20'h00002);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3 drain busy", 32'(fetch_busy), 32'd1);
        step(2);
        mem_ready = 1'b1;
        mem_rdata = 32'h00001234;
        step();
        mem_ready = 1'b0;
        check("t3 discard valid", 32'(instr_valid), 32'd0);
        check("t3 discard mem_rd", 32'(mem_rd), 32'd0);
        expect_req("t3 refetch", 20'h00002);
        respond("t3", 20'h00002, 32'h0B0B0002);
        accept("t3", 16'd3);

        // 4: PC moves while the word is held and not accepted
        pc_address = 20'h00005;
        expect_req("t4", 20'h00005);
        respond("t4", 20'h00005, 32'h00000055);
        pc_address = 20'h00040;
        step();
        check("t4 stale valid", 32'(instr_valid), 32'd0);
        check("t4 stale count", 32'(fetch_count), 32'd3);
        expect_req("t4 new", 20'h00040);
        respond("t4", 20'h00040, 32'h40404040);
        accept("t4", 16'd4);

        // Flush beats instr_ready in HOLD; the same address is then refetched
        pc_address = 20'h00006;
        expect_req("hf", 20'h00006);
        respond("hf", 20'h00006, 32'h66666666);
        flush = 1'b1;
        instr_ready = 1'b1;
        step();
        flush = 1'b0;
        instr_ready = 1'b0;
        check("hf valid", 32'(instr_valid), 32'd0);
        check("hf count", 32'(fetch_count), 32'd4);
        expect_req("hf refetch", 20'h00006);
        respond("hf", 20'h00006, 32'h66660006);
        accept("hf", 16'd5);

        // Flush and mem_ready in the same WAIT cycle drop the data
        pc_address = 20'h00007;
        expect_req("wf", 20'h00007);
        step();
        mem_ready = 1'b1;
        flush = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ready = 1'b0;
        flush = 1'b0;
        check("wf valid", 32'(instr_valid), 32'd0);
        expect_req("wf refetch", 20'h00007);
        respond("wf", 20'h00007, 32'h70707070);
        accept("wf", 16'd6);

        // 5: memory never answers
        pc_address = 20'h00008;
        expect_req("t5", 20'h00008);
`ifdef IF_TIMEOUT_EN
        step(255);
        check("t5 error before", 32'(fetch_error), 32'd0);
        check("t5 no retry yet", 32'(mem_rd), 32'd0);
        step();
        check("t5 error", 32'(fetch_error), 32'd1);
        check("t5 retry mem_rd", 32'(mem_rd), 32'd1);
        check("t5 retry addr", 32'(mem_addr), 32'h00008);
        respond("t5", 20'h00008, 32'h88888888);
        check("t5 error sticky", 32'(fetch_error), 32'd1);
`else
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            pulses += int'(mem_rd);
        end
        check("t5 no retry", 32'(pulses), 32'd0);
        check("t5 no error", 32'(fetch_error), 32'd0);
        check("t5 still busy", 32'(fetch_busy), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h88888888;
        step();
        mem_ready = 1'b0;
        check("t5 late valid", 32'(instr_valid), 32'd1);
        check("t5 late instr", instr, 32'h88888888);
`endif
        accept("t5", 16'd7);

        // 6: counter wrap, preset to 0xFFFF while idle
        force dut.r_fetch_count = 16'hFFFF;
        step();
        release dut.r_fetch_count;
        step();
        check("t6 preset", 32'(fetch_count), 32'h0000FFFF);
        pc_address = 20'h00009;
        expect_req("t6", 20'h00009);
        respond("t6", 20'h00009, 32'h99999999);
        accept("t6", 16'h0000);

        // Reset mid-fetch; a response arriving during reset is ignored
        pc_address = 20'h0000A;
        expect_req("rm", 20'h0000A);
        step();
        reset = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hBADBAD00;
        step();
        check("rm valid", 32'(instr_valid), 32'd0);
        check("rm count", 32'(fetch_count), 32'd0);
        check("rm mem_rd", 32'(mem_rd), 32'd0);
        check("rm instr", instr, 32'd0);
        reset = 1'b0;
        mem_ready = 1'b0;
        expect_req("rm refetch", 20'h0000A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
